// File: rtl/bsram_arb_pkg.sv
// Shared types and widths for the BSRAM port arbiter family.
// DPB_AD_W/DPB_D_W are the fixed Gowin DPB pin widths, independent of the configured word width.
package bsram_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;
    localparam int DPB_AD_W   = 14;
    localparam int DPB_D_W    = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

    typedef logic port_idx_t;

endpackage

// File: rtl/bsram_rr_grant.sv
// Two-way round-robin grant: a lone valid wins; on a tie the port not granted last wins.
// Purely combinational, one-hot (or zero) grant.
module bsram_rr_grant
    import bsram_arb_pkg::*;
(
    input  logic [1:0] vld_i,
    input  port_idx_t  last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (vld_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/bsram_port_arbiter.sv
// Round-robin share of one Gowin DPB port between two valid/ready clients; reads return after 1 cycle.
// Define BSRAM_ARB_CLEAR_EN to zero the whole memory after reset before any client is served.
module bsram_port_arbiter
    import bsram_arb_pkg::*;
#(
    parameter int         DATA_W  = DATA_W_DEF,
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter logic [2:0] BLK_SEL = 3'b000
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                REQ0_VALID,
    output logic                REQ0_READY,
    input  logic                REQ0_WE,
    input  logic [ADDR_W-1:0]   REQ0_ADDR,
    input  logic [DATA_W-1:0]   REQ0_WDATA,
    input  logic                REQ1_VALID,
    output logic                REQ1_READY,
    input  logic                REQ1_WE,
    input  logic [ADDR_W-1:0]   REQ1_ADDR,
    input  logic [DATA_W-1:0]   REQ1_WDATA,
    output logic                RSP0_VALID,
    output logic [DATA_W-1:0]   RSP0_RDATA,
    output logic                RSP1_VALID,
    output logic [DATA_W-1:0]   RSP1_RDATA,
    output logic                BUSY,
    output logic                MEM_CE,
    output logic                MEM_WRE,
    output logic                MEM_OCE,
    output logic                MEM_RESET,
    output logic [DPB_AD_W-1:0] MEM_AD,
    output logic [DPB_D_W-1:0]  MEM_DI,
    output logic [2:0]          MEM_BLKSEL,
    input  logic [DPB_D_W-1:0]  MEM_DO
);

    localparam int AD_SH = DPB_AD_W - ADDR_W;

    logic       run;
    logic [1:0] vld;
    logic [1:0] gnt;
    port_idx_t  last_q, last_d;
    logic       rsp0_q, rsp1_q;

`ifdef BSRAM_ARB_CLEAR_EN
    arb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == CLEAR) begin
            clr_d = clr_q + 1'b1;
            if (&clr_q) begin
                state_d = RUN;
            end
        end
    end

    assign run = (state_q == RUN);
`else
    assign run = 1'b1;
`endif

    // Clients are invisible to the arbiter while the sweep owns the port.
    assign vld = {REQ1_VALID, REQ0_VALID} & {2{run}};

    bsram_rr_grant u_grant (
        .vld_i  (vld),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    assign REQ0_READY = gnt[0];
    assign REQ1_READY = gnt[1];

    always_comb begin
        MEM_CE  = 1'b0;
        MEM_WRE = 1'b0;
        MEM_AD  = '0;
        MEM_DI  = '0;
        if (gnt[0]) begin
            MEM_CE  = 1'b1;
            MEM_WRE = REQ0_WE;
            MEM_AD  = DPB_AD_W'({REQ0_ADDR, {AD_SH{1'b0}}});
            MEM_DI  = DPB_D_W'(REQ0_WDATA);
        end else if (gnt[1]) begin
            MEM_CE  = 1'b1;
            MEM_WRE = REQ1_WE;
            MEM_AD  = DPB_AD_W'({REQ1_ADDR, {AD_SH{1'b0}}});
            MEM_DI  = DPB_D_W'(REQ1_WDATA);
        end
`ifdef BSRAM_ARB_CLEAR_EN
        if (!run) begin
            MEM_CE  = 1'b1;
            MEM_WRE = 1'b1;
            MEM_AD  = DPB_AD_W'({clr_q, {AD_SH{1'b0}}});
            MEM_DI  = '0;
        end
`endif
    end

    always_comb begin
        last_d = last_q;
        if (gnt[1]) begin
            last_d = 1'b1;
        end else if (gnt[0]) begin
            last_d = 1'b0;
        end
    end

    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            last_q <= 1'b1;
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
        end else begin
            last_q <= last_d;
            rsp0_q <= gnt[0] & ~REQ0_WE;
            rsp1_q <= gnt[1] & ~REQ1_WE;
        end
    end

    // The DPB registers DO on the accept edge, so its output lines up with the pulse.
    assign RSP0_VALID = rsp0_q;
    assign RSP1_VALID = rsp1_q;
    assign RSP0_RDATA = MEM_DO[DATA_W-1:0];
    assign RSP1_RDATA = MEM_DO[DATA_W-1:0];

    assign BUSY       = ~run;
    assign MEM_OCE    = 1'b1;
    assign MEM_RESET  = 1'b0;
    assign MEM_BLKSEL = BLK_SEL;

endmodule

// File: tb/tb_bsram_port_arbiter.sv
// Randomized bench for bsram_port_arbiter against a transaction-level round-robin/memory model.
// Honours BSRAM_ARB_CLEAR_EN to exercise the post-reset clear sweep.
module tb_bsram_port_arbiter;

`ifdef BSRAM_ARB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        REQ0_VALID, REQ0_WE, REQ1_VALID, REQ1_WE;
    logic [9:0]  REQ0_ADDR, REQ1_ADDR;
    logic [15:0] REQ0_WDATA, REQ1_WDATA;
    logic        REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, BUSY;
    logic [15:0] RSP0_RDATA, RSP1_RDATA;
    logic        MEM_CE, MEM_WRE, MEM_OCE, MEM_RESET;
    logic [13:0] MEM_AD;
    logic [15:0] MEM_DI;
    logic [2:0]  MEM_BLKSEL;
    logic [15:0] MEM_DO;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bsram_port_arbiter dut (
        .CLK(CLK), .RESETN(RESETN),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WE(REQ0_WE),
        .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WE(REQ1_WE),
        .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
        .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA),
        .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA),
        .BUSY(BUSY), .MEM_CE(MEM_CE), .MEM_WRE(MEM_WRE), .MEM_OCE(MEM_OCE),
        .MEM_RESET(MEM_RESET), .MEM_AD(MEM_AD), .MEM_DI(MEM_DI),
        .MEM_BLKSEL(MEM_BLKSEL), .MEM_DO(MEM_DO)
    );

    // Gowin DPB port stand-in: bypass read mode, normal write mode.
    logic [15:0] dpb_mem [1024];
    always @(posedge CLK) begin
        if (MEM_CE) begin
            if (MEM_WRE) dpb_mem[MEM_AD[13:4]] <= MEM_DI;
            else         MEM_DO <= dpb_mem[MEM_AD[13:4]];
        end
    end

    // Pending client requests and the reference model state.
    bit          p_vld [2];
    bit          p_we  [2];
    logic [9:0]  p_addr[2];
    logic [15:0] p_wd  [2];
    logic [15:0] ref_mem [1024];
    bit          known   [1024];
    bit          exp_v [2];
    bit          exp_k [2];
    logic [15:0] exp_d [2];
    int          last_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive();
        REQ0_VALID = p_vld[0]; REQ0_WE = p_we[0]; REQ0_ADDR = p_addr[0]; REQ0_WDATA = p_wd[0];
        REQ1_VALID = p_vld[1]; REQ1_WE = p_we[1]; REQ1_ADDR = p_addr[1]; REQ1_WDATA = p_wd[1];
    endtask

    // One clock: entered and left at #1 after a rising edge.
    task automatic step();
        int g;
        drive();
        @(negedge CLK);
        g = -1;
        if (p_vld[0] && p_vld[1]) g = (last_m == 1) ? 0 : 1;
        else if (p_vld[0])        g = 0;
        else if (p_vld[1])        g = 1;
        chk("ready0", REQ0_READY, g == 0);
        chk("ready1", REQ1_READY, g == 1);
        chk("busy", BUSY, 0);
        chk("ce", MEM_CE, g >= 0);
        if (g >= 0) begin
            chk("wre", MEM_WRE, p_we[g]);
            chk("ad", MEM_AD, 32'(p_addr[g]) << 4);
            if (p_we[g]) chk("di", MEM_DI, p_wd[g]);
        end else begin
            chk("idle_wre", MEM_WRE, 0);
            chk("idle_ad", MEM_AD, 0);
            chk("idle_di", MEM_DI, 0);
        end
        chk("rsp0_vld", RSP0_VALID, exp_v[0]);
        chk("rsp1_vld", RSP1_VALID, exp_v[1]);
        if (exp_v[0] && exp_k[0]) chk("rsp0_dat", RSP0_RDATA, exp_d[0]);
        if (exp_v[1] && exp_k[1]) chk("rsp1_dat", RSP1_RDATA, exp_d[1]);
        exp_v[0] = 0;
        exp_v[1] = 0;
        if (g >= 0) begin
            last_m = g;
            if (p_we[g]) begin
                ref_mem[p_addr[g]] = p_wd[g];
                known[p_addr[g]]   = 1;
            end else begin
                exp_v[g] = 1;
                exp_d[g] = ref_mem[p_addr[g]];
                exp_k[g] = known[p_addr[g]];
            end
            p_vld[g] = 0;
        end
        @(posedge CLK); #1;
    endtask

    task automatic set_req(input int p, input bit we, input logic [9:0] a, input logic [15:0] d);
        p_vld[p] = 1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
    endtask

    // Watches a clear sweep; optionally pulses reset once when address `cut` is on the bus.
    task automatic run_sweep(input int cut);
        int n = 0, bad = 0, rdy = 0;
        REQ0_VALID = 1; REQ0_WE = 0; REQ1_VALID = 1; REQ1_WE = 0;
        for (int c = 0; c < 2600; c++) begin
            @(negedge CLK);
            if (!BUSY) break;
            if (cut > 0 && n == cut) begin
                RESETN = 0;
                #1;
                chk("cut_ad", MEM_AD, 0);
                chk("cut_busy", BUSY, 1);
                @(posedge CLK); #1;
                RESETN = 1;
                n = 0;
                cut = 0;
                continue;
            end
            if (MEM_AD !== 14'(n << 4) || MEM_CE !== 1 || MEM_WRE !== 1 || MEM_DI !== 0) bad++;
            if (REQ0_READY || REQ1_READY) rdy++;
            n++;
        end
        REQ0_VALID = 0;
        REQ1_VALID = 0;
        chk("sweep_done", BUSY, 0);
        chk("sweep_len", n, 1024);
        chk("sweep_bad", bad, 0);
        chk("sweep_rdy", rdy, 0);
        @(posedge CLK); #1;
    endtask

    task automatic apply_reset(input int cut);
        RESETN = 0;
        p_vld[0] = 0; p_vld[1] = 0;
        p_we[0] = 0; p_we[1] = 0;
        drive();
        exp_v[0] = 0; exp_v[1] = 0;
        last_m = 1;
        @(negedge CLK);
        chk("rst_rdy0", REQ0_READY, 0);
        chk("rst_rdy1", REQ1_READY, 0);
        chk("rst_rsp0", RSP0_VALID, 0);
        chk("rst_rsp1", RSP1_VALID, 0);
        chk("rst_busy", BUSY, CLR_EN);
        chk("rst_oce", MEM_OCE, 1);
        chk("rst_mreset", MEM_RESET, 0);
        chk("rst_blksel", MEM_BLKSEL, 0);
`ifndef BSRAM_ARB_CLEAR_EN
        chk("rst_ce", MEM_CE, 0);
        chk("rst_wre", MEM_WRE, 0);
        chk("rst_ad", MEM_AD, 0);
        chk("rst_di", MEM_DI, 0);
`endif
        @(posedge CLK); #1;
        RESETN = 1;
`ifdef BSRAM_ARB_CLEAR_EN
        run_sweep(cut);
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 16'h0000;
            known[i]   = 1;
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 16'h0000;
            known[i]   = 0;
        end
        for (int p = 0; p < 2; p++) begin
            p_addr[p] = '0; p_wd[p] = '0; exp_d[p] = '0; exp_k[p] = 0;
        end
        apply_reset(0);

`ifdef BSRAM_ARB_CLEAR_EN
        set_req(0, 0, 10'd0, 16'h0);
        step();
        set_req(1, 0, 10'd1023, 16'h0);
        step();
        step();
        apply_reset(300);
`else
        // First cycle after reset with VALID high must be accepted.
        set_req(0, 1, 10'h12A, 16'h1234);
        step();
`endif
        set_req(0, 1, 10'h12A, 16'hBEEF);
        step();
        set_req(0, 0, 10'h12A, 16'h0);
        step();
        // last-granted is now port 0, so the port-1 write goes first.
        set_req(1, 1, 10'd7, 16'h5555);
        set_req(0, 0, 10'd7, 16'h0);
        step();
        step();
        step();

        apply_reset(0);
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < 2; p++)
                if (!p_vld[p]) set_req(p, 0, 10'($urandom_range(0, 15)), 16'h0);
            step();
        end

        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_vld[p] && $urandom_range(0, 3) != 0) begin
                    set_req(p, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15)),
                            16'($urandom));
                end
            end
            step();
        end
        p_vld[0] = 0;
        p_vld[1] = 0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
